conv3x3_kernel_mc: RTL and testbench

//  Multi-channel, mode-selectable 3x3 neighbourhood filter for the video pipeline. It sits

---
 rtl/conv3x3_kernel_mc.sv | 175 +++++++++++++++++
 tb/tb_conv3x3_kernel_mc.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv3x3_kernel_mc.sv
// Multi-channel 3x3 neighbourhood filter (bypass / gaussian / box / sharpen) with a
// three-stage elastic pipeline and frame-synchronous mode switching.
module conv3x3_kernel_mc #(
   parameter int VIDEO_DATA_WIDTH = 8,
   parameter int CHANNELS         = 3
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic [1:0]                             cfg_mode,
   input  logic [9*CHANNELS*VIDEO_DATA_WIDTH-1:0] in_data,
   input  logic                                   in_valid,
   input  logic                                   in_sof,
   input  logic                                   in_eol,
   output logic                                   in_ready,
   output logic [CHANNELS*VIDEO_DATA_WIDTH-1:0]   out_data,
   output logic                                   out_valid,
   output logic                                   out_sof,
   output logic                                   out_eol,
   input  logic                                   out_ready
);

   localparam int W  = VIDEO_DATA_WIDTH;
   localparam int C  = CHANNELS;
   localparam int SW = W + 5;
   localparam int PW = W + 13;
   localparam logic signed [PW:0] MAXV = (PW+1)'((1 << W) - 1);

   typedef enum logic [1:0] {
      MODE_BYPASS  = 2'd0,
      MODE_GAUSS   = 2'd1,
      MODE_BOX     = 2'd2,
      MODE_SHARPEN = 2'd3
   } mode_t;

   mode_t active_mode;
   mode_t beat_mode;
   mode_t mode1;
   mode_t mode2;

   logic v1;
   logic v2;
   logic ld1;
   logic ld2;
   logic ld3;
   logic accept;
   logic sof1;
   logic eol1;
   logic sof2;
   logic eol2;

   logic signed [SW-1:0] wt_next  [C][9];
   logic signed [SW-1:0] wt1      [C][9];
   logic signed [SW-1:0] sum_next [C];
   logic signed [SW-1:0] sum2     [C];
   logic [C*W-1:0]       res_next;

   // A stage may take a new beat when it is empty or its successor takes its current one.
   assign ld3      = !out_valid || out_ready;
   assign ld2      = !v2 || ld3;
   assign ld1      = !v1 || ld2;
   assign in_ready = ld1;
   assign accept   = in_valid && in_ready;

   // The start-of-frame beat already runs in the mode it requests.
   assign beat_mode = in_sof ? mode_t'(cfg_mode) : active_mode;

   function automatic logic signed [3:0] tap_weight(input mode_t m, input int k);
      logic signed [3:0] w;
      w = 4'sd0;
      case (m)
         MODE_BYPASS:  w = (k == 4) ? 4'sd1 : 4'sd0;
         MODE_GAUSS:   w = (k == 4) ? 4'sd4 : (((k % 2) == 1) ? 4'sd2 : 4'sd1);
         MODE_BOX:     w = 4'sd1;
         MODE_SHARPEN: w = (k == 4) ? 4'sd5 : (((k % 2) == 1) ? -4'sd1 : 4'sd0);
         default:      w = 4'sd0;
      endcase
      return w;
   endfunction

   // Stage 1 combinational: weight every tap of every channel by the beat's mode.
   always_comb begin
      for (int c = 0; c < C; c++) begin
         for (int k = 0; k < 9; k++) begin
            wt_next[c][k] = signed'(SW'(in_data[(c*9+k)*W +: W])) * SW'(tap_weight(beat_mode, k));
         end
      end
   end

   // Stage 2 combinational: adder tree over the nine weighted taps.
   always_comb begin
      for (int c = 0; c < C; c++) begin
         sum_next[c] = '0;
         for (int k = 0; k < 9; k++) begin
            sum_next[c] = sum_next[c] + wt1[c][k];
         end
      end
   end

   // Stage 3 combinational: normalise per mode, round, then clamp to the sample range.
   always_comb begin
      logic signed [PW:0] r;
      logic [PW-1:0]      prod;
      res_next = '0;
      for (int c = 0; c < C; c++) begin
         r    = '0;
         prod = PW'(sum2[c][W+3:0]) * PW'(455) + PW'(2048);
         case (mode2)
            MODE_GAUSS: r = (PW+1)'((sum2[c] + SW'(8)) >>> 4);
            MODE_BOX:   r = signed'({1'b0, prod >> 12});
            default:    r = (PW+1)'(sum2[c]);
         endcase
         if (r < 0) begin
            res_next[c*W +: W] = '0;
         end else if (r > MAXV) begin
            res_next[c*W +: W] = '1;
         end else begin
            res_next[c*W +: W] = r[W-1:0];
         end
      end
   end

   // Control, mode register and output stage; reset flushes every in-flight beat.
   always_ff @(posedge clk) begin
      if (rst) begin
         v1          <= 1'b0;
         v2          <= 1'b0;
         out_valid   <= 1'b0;
         out_data    <= '0;
         out_sof     <= 1'b0;
         out_eol     <= 1'b0;
         active_mode <= MODE_GAUSS;
      end else begin
         if (accept && in_sof) begin
            active_mode <= mode_t'(cfg_mode);
         end
         if (ld1) begin
            v1 <= in_valid;
         end
         if (ld2) begin
            v2 <= v1;
         end
         if (ld3) begin
            out_valid <= v2;
            if (v2) begin
               out_data <= res_next;
               out_sof  <= sof2;
               out_eol  <= eol2;
            end
         end
      end
   end

   // Payload registers follow their stage's load enable; the mode travels with the beat.
   always_ff @(posedge clk) begin
      if (ld1) begin
         for (int c = 0; c < C; c++) begin
            for (int k = 0; k < 9; k++) begin
               wt1[c][k] <= wt_next[c][k];
            end
         end
         mode1 <= beat_mode;
         sof1  <= in_sof;
         eol1  <= in_eol;
      end
      if (ld2) begin
         for (int c = 0; c < C; c++) begin
            sum2[c] <= sum_next[c];
         end
         mode2 <= mode1;
         sof2  <= sof1;
         eol2  <= eol1;
      end
   end

endmodule

// File: tb/tb_conv3x3_kernel_mc.sv
// Self-checking bench for conv3x3_kernel_mc: constant vector table, backpressure and
// reset sequences, and randomized traffic against a formula-level scoreboard model.
module tb_conv3x3_kernel_mc;

   localparam int W    = 8;
   localparam int C    = 3;
   localparam int MAXV = (1 << W) - 1;

   logic               clk = 1'b0;
   logic               rst;
   logic [1:0]         cfg_mode;
   logic [9*C*W-1:0]   in_data;
   logic               in_valid;
   logic               in_sof;
   logic               in_eol;
   logic               in_ready;
   logic [C*W-1:0]     out_data;
   logic               out_valid;
   logic               out_sof;
   logic               out_eol;
   logic               out_ready;

   conv3x3_kernel_mc #(
      .VIDEO_DATA_WIDTH (W),
      .CHANNELS         (C)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .cfg_mode  (cfg_mode),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_sof    (in_sof),
      .in_eol    (in_eol),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_sof   (out_sof),
      .out_eol   (out_eol),
      .out_ready (out_ready)
   );

   always #5 clk = ~clk;

   typedef struct {
      string      name;
      logic [1:0] mode;
      logic       sof;
      int         center;
      int         edg;
      int         corner;
      int         expected;
   } vec_t;

   typedef struct {
      logic [C*W-1:0] data;
      logic           sof;
      logic           eol;
   } beat_t;

   vec_t           vecs[15];
   beat_t          sb[$];
   int             taps[C][9];
   int             tests_run    = 0;
   int             tests_failed = 0;
   int             model_mode   = 1;
   int             pushes       = 0;
   int             pops         = 0;
   int             max_out      = 0;
   logic           saw_block    = 1'b0;
   logic           last_accept  = 1'b0;
   logic           stall_prev   = 1'b0;
   logic [C*W-1:0] stall_data   = '0;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      tests_run++;
      if (actual !== expected) begin
         tests_failed++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   // Filter output straight from the arithmetic definitions of each mode.
   function automatic int refPixel(input int mode, input int t[9]);
      int s;
      int r;
      s = 0;
      r = 0;
      case (mode)
         0: r = t[4];
         1: begin
            s = t[0] + t[2] + t[6] + t[8] + 2*(t[1] + t[3] + t[5] + t[7]) + 4*t[4];
            r = (s + 8) / 16;
         end
         2: begin
            for (int k = 0; k < 9; k++) s += t[k];
            r = (s*455 + 2048) / 4096;
         end
         default: r = 5*t[4] - t[1] - t[3] - t[5] - t[7];
      endcase
      if (r < 0) r = 0;
      if (r > MAXV) r = MAXV;
      return r;
   endfunction

   function automatic logic [C*W-1:0] refBeat(input int mode);
      logic [C*W-1:0] d;
      int             row[9];
      d = '0;
      for (int c = 0; c < C; c++) begin
         for (int k = 0; k < 9; k++) row[k] = taps[c][k];
         d[c*W +: W] = W'(refPixel(mode, row));
      end
      return d;
   endfunction

   task automatic setPattern(input int center, input int edg, input int corner);
      for (int c = 0; c < C; c++) begin
         for (int k = 0; k < 9; k++) begin
            taps[c][k] = (k == 4) ? center : (((k % 2) == 1) ? edg : corner);
         end
      end
   endtask

   task automatic randomTaps();
      int sel;
      for (int c = 0; c < C; c++) begin
         for (int k = 0; k < 9; k++) begin
            sel = $urandom_range(0, 9);
            taps[c][k] = (sel == 0) ? 0 : ((sel == 1) ? MAXV : int'($urandom_range(0, MAXV)));
         end
      end
   endtask

   task automatic applyStimulus(input logic valid, input logic sof, input logic eol, input logic [1:0] mode);
      for (int c = 0; c < C; c++) begin
         for (int k = 0; k < 9; k++) begin
            in_data[(c*9+k)*W +: W] = W'(taps[c][k]);
         end
      end
      in_valid = valid;
      in_sof   = sof;
      in_eol   = eol;
      cfg_mode = mode;
   endtask

   // One clock of scoreboarded traffic; entered just after a falling edge with inputs driven.
   task automatic cycleStep();
      int    occ;
      int    eff;
      beat_t b;
      #1;
      occ = pushes - pops;
      if (occ > max_out) max_out = occ;
      if (in_valid && !in_ready && occ == 3) saw_block = 1'b1;
      last_accept = in_valid && in_ready;
      if (stall_prev) begin
         checkOutput("stall_valid", 32'(out_valid), 32'd1);
         checkOutput("stall_data", 32'(out_data), 32'(stall_data));
      end
      if (out_valid && out_ready) begin
         checkOutput("sb_nonempty", 32'(sb.size() > 0), 32'd1);
         if (sb.size() > 0) begin
            b = sb.pop_front();
            checkOutput("sb_data", 32'(out_data), 32'(b.data));
            checkOutput("sb_sof", 32'(out_sof), 32'(b.sof));
            checkOutput("sb_eol", 32'(out_eol), 32'(b.eol));
         end
         pops++;
      end
      if (last_accept) begin
         eff = in_sof ? int'(cfg_mode) : model_mode;
         if (in_sof) model_mode = int'(cfg_mode);
         b.data = refBeat(eff);
         b.sof  = in_sof;
         b.eol  = in_eol;
         sb.push_back(b);
         pushes++;
      end
      stall_prev = out_valid && !out_ready;
      stall_data = out_data;
      @(posedge clk);
      @(negedge clk);
   endtask

   // Isolated beat into an empty pipeline: checks acceptance, exact latency and value.
   task automatic singleBeat(input vec_t v);
      logic [C*W-1:0] exp_data;
      for (int c = 0; c < C; c++) exp_data[c*W +: W] = W'(v.expected);
      setPattern(v.center, v.edg, v.corner);
      applyStimulus(1'b1, v.sof, 1'b1, v.mode);
      #1 checkOutput({v.name, "_ready"}, 32'(in_ready), 32'd1);
      if (v.sof) model_mode = int'(v.mode);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      in_sof   = 1'b0;
      in_eol   = 1'b0;
      @(posedge clk);
      #1 checkOutput({v.name, "_lat2"}, 32'(out_valid), 32'd0);
      @(posedge clk);
      #1;
      checkOutput({v.name, "_valid"}, 32'(out_valid), 32'd1);
      checkOutput({v.name, "_data"}, 32'(out_data), 32'(exp_data));
      checkOutput({v.name, "_sof"}, 32'(out_sof), 32'(v.sof));
      checkOutput({v.name, "_eol"}, 32'(out_eol), 32'd1);
      @(negedge clk);
   endtask

   initial begin
      int   nxt;
      int   pops0;
      vec_t post;

      vecs[0]  = '{"gauss_flat100",   2'd1, 1'b1, 100, 100, 100, 100};
      vecs[1]  = '{"gauss_center255", 2'd1, 1'b1, 255,   0,   0,  64};
      vecs[2]  = '{"box_flat200",     2'd2, 1'b1, 200, 200, 200, 200};
      vecs[3]  = '{"box_flat255",     2'd2, 1'b1, 255, 255, 255, 255};
      vecs[4]  = '{"sharp_clamp_hi",  2'd3, 1'b1, 100,   0,   0, 255};
      vecs[5]  = '{"sharp_clamp_lo",  2'd3, 1'b1,   0, 255,   0,   0};
      vecs[6]  = '{"bypass_center",   2'd0, 1'b1,  37, 200,   9,  37};
      vecs[7]  = '{"sharp_mid",       2'd3, 1'b1,  60,  20, 255, 220};
      vecs[8]  = '{"gauss_corners",   2'd1, 1'b1,   0,   0, 255,  64};
      vecs[9]  = '{"box_round_dn",    2'd2, 1'b1,  10,   0,   0,   1};
      vecs[10] = '{"box_round_up",    2'd2, 1'b1,   0,   1,   1,   1};
      vecs[11] = '{"gauss_round",     2'd1, 1'b1,   3,   1,   0,   1};
      vecs[12] = '{"midframe_ignore", 2'd2, 1'b0, 255,   0,   0,  64};
      vecs[13] = '{"sof_switch",      2'd3, 1'b1, 255,   0,   0, 255};
      vecs[14] = '{"midframe_keep",   2'd0, 1'b0,  60,  20, 255, 220};

      rst       = 1'b1;
      in_valid  = 1'b0;
      in_sof    = 1'b0;
      in_eol    = 1'b0;
      in_data   = '0;
      cfg_mode  = 2'd0;
      out_ready = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      #1;
      checkOutput("reset_valid", 32'(out_valid), 32'd0);
      checkOutput("reset_data", 32'(out_data), 32'd0);
      checkOutput("reset_sof", 32'(out_sof), 32'd0);
      checkOutput("reset_eol", 32'(out_eol), 32'd0);
      rst = 1'b0;
      @(posedge clk);
      #1 checkOutput("reset_ready", 32'(in_ready), 32'd1);
      @(negedge clk);

      for (int i = 0; i < 15; i++) singleBeat(vecs[i]);
      @(posedge clk);
      @(negedge clk);

      // Ten-beat frame with the sink stalled for cycles 2..8.
      $display("[TB] backpressure sequence");
      pops0     = pops;
      max_out   = 0;
      saw_block = 1'b0;
      nxt       = 0;
      randomTaps();
      for (int n = 0; n < 60; n++) begin
         if (nxt >= 10 && sb.size() == 0) break;
         out_ready = !(n >= 2 && n <= 8);
         applyStimulus(nxt < 10, nxt == 0, (nxt == 4) || (nxt == 9), 2'd1);
         cycleStep();
         if (last_accept) begin
            nxt++;
            randomTaps();
         end
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      checkOutput("bp_count", 32'(pops - pops0), 32'd10);
      checkOutput("bp_blocked", 32'(saw_block), 32'd1);
      checkOutput("bp_depth", 32'(max_out), 32'd3);

      $display("[TB] randomized traffic");
      for (int n = 0; n < 400; n++) begin
         randomTaps();
         out_ready = ($urandom_range(0, 3) != 0);
         applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0,
                       $urandom_range(0, 5) == 0, 2'($urandom_range(0, 3)));
         cycleStep();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int n = 0; n < 20 && sb.size() > 0; n++) cycleStep();
      checkOutput("drain_empty", 32'(sb.size()), 32'd0);

      // Reset with three beats held in the stalled pipeline.
      $display("[TB] reset with beats in flight");
      out_ready = 1'b0;
      for (int n = 0; n < 3; n++) begin
         randomTaps();
         applyStimulus(1'b1, n == 0, 1'b0, 2'd2);
         cycleStep();
      end
      in_valid = 1'b0;
      #1;
      checkOutput("inflight_valid", 32'(out_valid), 32'd1);
      checkOutput("inflight_depth", 32'(pushes - pops), 32'd3);
      rst = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("rst_flush_valid", 32'(out_valid), 32'd0);
      checkOutput("rst_flush_data", 32'(out_data), 32'd0);
      checkOutput("rst_flush_sof", 32'(out_sof), 32'd0);
      checkOutput("rst_flush_eol", 32'(out_eol), 32'd0);
      @(negedge clk);
      rst        = 1'b0;
      out_ready  = 1'b1;
      stall_prev = 1'b0;
      model_mode = 1;
      sb.delete();
      #1 checkOutput("rst_release_ready", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1 checkOutput("rst_no_ghost", 32'(out_valid), 32'd0);
      @(negedge clk);
      post = '{"post_reset_gauss", 2'd3, 1'b0, 255, 100, 100, 139};
      singleBeat(post);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
